// File: rtl/pm_sort_if.sv
// Handshake bundle for pm_sort_sched: metric vector in, sorted vector out.
// master drives vectors and consumes results; slave is the sorter.
interface pm_sort_if #(
  parameter int PM_WIDTH  = 8,
  parameter int LIST_SIZE = 8,
  parameter int IDX_WIDTH = 3
) ();
  logic                           in_valid;
  logic                           in_ready;
  logic [LIST_SIZE*PM_WIDTH-1:0]  in_pm;
  logic                           out_valid;
  logic                           out_ready;
  logic [LIST_SIZE*PM_WIDTH-1:0]  out_pm;
  logic [LIST_SIZE*IDX_WIDTH-1:0] out_idx;

  modport master (
    output in_valid, in_pm, out_ready,
    input  in_ready, out_valid, out_pm, out_idx
  );

  modport slave (
    input  in_valid, in_pm, out_ready,
    output in_ready, out_valid, out_pm, out_idx
  );
endinterface

// File: rtl/pm_sort_sched.sv
// Odd-even transposition path-metric sorter, one phase per clock, stable.
// Optional SORT_EARLY_EXIT_EN ends after a clean even/odd phase pair.
module pm_sort_sched #(
  parameter int PM_WIDTH  = 8,
  parameter int LIST_SIZE = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  pm_sort_if.slave bus,
  output logic     busy
);
  localparam int PW = $clog2(LIST_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  state_t               state;
  logic [PM_WIDTH-1:0]  pm      [LIST_SIZE];
  logic [IDX_WIDTH-1:0] idx     [LIST_SIZE];
  logic [PM_WIDTH-1:0]  nxt_pm  [LIST_SIZE];
  logic [IDX_WIDTH-1:0] nxt_idx [LIST_SIZE];
  logic [PW-1:0]        ph;
  logic                 last;
  logic                 in_ready_q;
  logic                 out_valid_q;
`ifdef SORT_EARLY_EXIT_EN
  logic                 any_sw;
  logic                 sw_even;
`endif

  // Every compare reads the registered slots, so one phase is parallel.
  always_comb begin
`ifdef SORT_EARLY_EXIT_EN
    any_sw = 1'b0;
`endif
    for (int i = 0; i < LIST_SIZE; i++) begin
      nxt_pm[i]  = pm[i];
      nxt_idx[i] = idx[i];
    end
    if (!ph[0]) begin
      for (int k = 0; k < LIST_SIZE; k += 2) begin
        if (pm[k] > pm[k+1]) begin
          nxt_pm[k]    = pm[k+1];
          nxt_pm[k+1]  = pm[k];
          nxt_idx[k]   = idx[k+1];
          nxt_idx[k+1] = idx[k];
`ifdef SORT_EARLY_EXIT_EN
          any_sw = 1'b1;
`endif
        end
      end
    end else begin
      for (int k = 1; k < LIST_SIZE - 1; k += 2) begin
        if (pm[k] > pm[k+1]) begin
          nxt_pm[k]    = pm[k+1];
          nxt_pm[k+1]  = pm[k];
          nxt_idx[k]   = idx[k+1];
          nxt_idx[k+1] = idx[k];
`ifdef SORT_EARLY_EXIT_EN
          any_sw = 1'b1;
`endif
        end
      end
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  assign last = (ph == PW'(LIST_SIZE - 1))
             || (ph[0] && !any_sw && !sw_even);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_even <= 1'b0;
    end else if (state == SORT && !ph[0]) begin
      sw_even <= any_sw;
    end
  end
`else
  assign last = (ph == PW'(LIST_SIZE - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ph          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < LIST_SIZE; i++) begin
        pm[i]  <= '0;
        idx[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            for (int i = 0; i < LIST_SIZE; i++) begin
              pm[i]  <= bus.in_pm[i*PM_WIDTH +: PM_WIDTH];
              idx[i] <= IDX_WIDTH'(i);
            end
            ph         <= '0;
            state      <= SORT;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SORT: begin
          for (int i = 0; i < LIST_SIZE; i++) begin
            pm[i]  <= nxt_pm[i];
            idx[i] <= nxt_idx[i];
          end
          ph <= ph + PW'(1);
          if (last) begin
            state       <= DONE;
            busy        <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after the result handshake, no bypass.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  for (genvar g = 0; g < LIST_SIZE; g++) begin : g_out
    assign bus.out_pm[g*PM_WIDTH +: PM_WIDTH]    = pm[g];
    assign bus.out_idx[g*IDX_WIDTH +: IDX_WIDTH] = idx[g];
  end
endmodule
